ad7687_reader: RTL and testbench
================================

// Module: ad7687_reader
// PURPOSE
//  SPI-style capture engine for a 16-bit AD7687/AD7980-class SAR ADC. It is the
//  receive-side counterpart of the ad5541 DAC writer.
//  On a start request it raises CNV for a fixed conversion time, then clocks the
//  result out of the ADC on SCLK and shifts it in MSB-first from SDO.
//  It presents the word with a one-cycle valid pulse.
//  It sits between the ADC pins and the sample-processing pipeline, in the same
//  clock domain as the DAC writer.
// PARAMETERS
//  DATA_WIDTH   16   bits per conversion result
//  CLK_DIV      4    clk cycles per SCLK half-period (>=1)
//  CONV_CYCLES  300  clk cycles CNV is held high (>=1)
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rstn          in   1           asynchronous active-low reset
//  start         in   1           conversion request, sampled only in IDLE
//  sdo           in   1           ADC serial data out
//  cnv           out  1           ADC convert strobe
//  sclk          out  1           ADC serial clock, idles low
//  data          out  DATA_WIDTH  last captured result, held until next capture
//  valid         out  1           one-cycle pulse when data updates
//  busy          out  1           high in any state other than IDLE
//  export_state  out  3           current FSM state code, for debug
// BEHAVIOUR
//  - Reset (rstn low, async): state=IDLE, cnv=0, sclk=0, data=0, valid=0,
//    busy=0, all counters=0. A partial word is discarded; no valid is issued.
//  - States and codes: IDLE=0, CONVERT=1, ACQ=2, DONE=3. Codes 4-7 are unused
//    and recover to IDLE on the next clk.
//  - IDLE: if start=1, go to CONVERT. cnv=1 and the conversion counter is cleared.
//  - CONVERT: cnv held high for exactly CONV_CYCLES clk cycles. Then cnv=0, go to
//    ACQ, and clear the divider and bit counters.
//  - ACQ:
//    - The divider counts 0..CLK_DIV-1. On wrap, sclk toggles. The first toggle
//      (rising) comes CLK_DIV cycles after entering ACQ.
//    - On each clk edge where sclk goes 0->1, sdo is shifted into the LSB of the
//      shift register (MSB of the result arrives first) and the bit counter
//      increments.
//    - After 2*DATA_WIDTH toggles (the last one is falling, so sclk=0), go to DONE.
//  - DONE (1 cycle): data<=shift register, valid=1, then go to IDLE. valid is 0
//    in all other cycles.
//  - Latency: valid is high on clk edge N after the edge that sampled start, with
//    N = CONV_CYCLES + 2*CLK_DIV*DATA_WIDTH + 1.
//  - Data stays stable from the valid edge until the next valid.
//  - start outside IDLE is ignored; requests are not queued.
//  - If start is held high continuously, conversions repeat back-to-back with a
//    period of N+1 clk cycles.
//  - cnv and sclk are never high in the same cycle. sclk is 0 outside ACQ.
//  - sdo is sampled directly (synchronous to generated sclk); no synchronizer.
//  - Counters are sized for the parameter values and never wrap mid-state.
// TESTING
//  1. Hold reset, then release with start=0 -> cnv=0, sclk=0, valid=0, data=0,
//     busy=0, export_state=0 for 50 cycles.
//  2. Single start pulse; ADC model drives 16'h004F on sdo -> cnv high for
//     exactly 300 cycles, 16 sclk rising edges, data=16'h004F, exactly one valid
//     pulse at N=429.
//  3. Patterns 16'h0000, 16'hFFFF, 16'hA5A5, 16'h8001 -> data matches each
//     pattern, confirming MSB-first order.
//  4. start pulsed during CONVERT and during ACQ -> no extra conversion, and
//     exactly one valid per accepted start.
//  5. start held high for 5 conversions -> 5 valid pulses spaced 430 cycles
//     apart, data correct each time.
//  6. Assert rstn low midway through ACQ -> cnv/sclk/valid go to 0
//     immediately, data=0. A following start gives a correct result
//     (16'h1234).

Source files
------------

// File: rtl/ad7687_reader.sv
// Capture engine for a 16-bit AD7687/AD7980-class SAR ADC: pulses CNV, then clocks
// the result out on SCLK MSB-first and presents it with a one-cycle valid strobe.
module ad7687_reader #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CONV_CYCLES = 300
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  sdo,
    output logic                  cnv,
    output logic                  sclk,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  busy,
    output logic [2:0]            export_state
);

    localparam int unsigned CW  = $clog2(CONV_CYCLES + 1);
    localparam int unsigned DVW = $clog2(CLK_DIV + 1);
    localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        ACQ     = 3'd2,
        DONE    = 3'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         conv_cnt;
    logic [DVW-1:0]        div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    logic conv_last;
    logic div_wrap;
    logic sclk_rise;
    logic acq_done;
    logic valid_nxt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unused codes fall back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (conv_last) state_nxt = ACQ;
            ACQ:     if (acq_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control decode
    always_comb begin
        conv_last = 1'b0;
        div_wrap  = 1'b0;
        sclk_rise = 1'b0;
        acq_done  = 1'b0;
        valid_nxt = 1'b0;
        case (state)
            CONVERT: conv_last = (conv_cnt == CW'(CONV_CYCLES - 1));
            ACQ: begin
                div_wrap  = (div_cnt == DVW'(CLK_DIV - 1));
                sclk_rise = div_wrap && !sclk;
                // last toggle is the falling edge after the final captured bit
                acq_done  = div_wrap && sclk && (bit_cnt == BW'(DATA_WIDTH));
            end
            DONE:    valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered outputs, counters and shift register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnv      <= 1'b0;
            sclk     <= 1'b0;
            data     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            conv_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            cnv   <= (state_nxt == CONVERT);
            busy  <= (state_nxt != IDLE);
            valid <= valid_nxt;
            if (valid_nxt) begin
                data <= shreg;
            end

            conv_cnt <= (state == CONVERT) ? conv_cnt + CW'(1) : '0;

            if (state == ACQ && !div_wrap) begin
                div_cnt <= div_cnt + DVW'(1);
            end else begin
                div_cnt <= '0;
            end

            if (state != ACQ) begin
                sclk <= 1'b0;
            end else if (div_wrap) begin
                sclk <= ~sclk;
            end

            if (state != ACQ) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (sclk_rise) begin
                shreg <= {shreg[DATA_WIDTH-2:0], sdo};
            end
        end
    end

    assign export_state = state;

endmodule

// File: tb/tb_ad7687_reader.sv
// Directed/randomized bench for ad7687_reader with a behavioural ADC model and
// a scoreboard of expected words, latencies and pin-level properties.
module tb_ad7687_reader;

    localparam int unsigned DW     = 16;
    localparam int unsigned CLKDIV = 4;
    localparam int unsigned CONV   = 300;
    localparam int unsigned N      = CONV + 2 * CLKDIV * DW + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          sdo;
    logic          cnv;
    logic          sclk;
    logic [DW-1:0] data;
    logic          valid;
    logic          busy;
    logic [2:0]    export_state;

    ad7687_reader #(.DATA_WIDTH(DW), .CLK_DIV(CLKDIV), .CONV_CYCLES(CONV)) dut (
        .clk(clk), .rstn(rstn), .start(start), .sdo(sdo), .cnv(cnv), .sclk(sclk),
        .data(data), .valid(valid), .busy(busy), .export_state(export_state)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;
    int unsigned cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC model: MSB presented when CNV rises, next bit after every SCLK fall
    logic [DW-1:0] adc_q[$];
    logic [DW-1:0] adc_word = '0;
    int            adc_idx  = 0;

    initial begin
        sdo = 1'b0;
        forever begin
            @(posedge cnv or negedge sclk);
            if (cnv) begin
                adc_idx = DW - 1;
                if (adc_q.size() > 0) adc_word = adc_q.pop_front();
            end else if (adc_idx > 0) begin
                adc_idx--;
            end
            sdo = adc_word[adc_idx];
        end
    end

    // Pin monitor sampled mid-cycle
    logic [DW-1:0] got_data[$];
    int unsigned   got_cyc[$];
    int unsigned   cnv_run = 0, cnv_len = 0, rises = 0, overlap = 0;
    logic          sclk_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cnv) cnv_run++;
        else if (cnv_run != 0) begin
            cnv_len = cnv_run;
            cnv_run = 0;
        end
        if (sclk && !sclk_prev) rises++;
        sclk_prev = sclk;
        if (cnv && sclk) overlap++;
        if (valid) begin
            got_data.push_back(data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_cyc.delete();
        cnv_len = 0;
        cnv_run = 0;
        rises   = 0;
        overlap = 0;
    endtask

    task automatic wait_valids(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (got_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got_data.size() < n) check({tag, "_timeout"}, got_data.size(), n);
    endtask

    task automatic run_one(input logic [DW-1:0] w, input string tag);
        int unsigned st;
        clear_mon();
        adc_q.push_back(w);
        @(negedge clk);
        start = 1'b1;
        st    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_state"}, export_state, 1);
        wait_valids(1, N + 50, tag);
        repeat (3) @(negedge clk);
        check({tag, "_nvalid"}, got_data.size(), 1);
        if (got_data.size() > 0) begin
            check({tag, "_data"}, got_data[0], w);
            check({tag, "_latency"}, got_cyc[0] - st, N);
        end
        check({tag, "_cnv_len"}, cnv_len, CONV);
        check({tag, "_rises"}, rises, DW);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_held"}, data, w);
        check({tag, "_idle"}, {valid, busy, sclk, cnv, export_state}, 0);
    endtask

    initial begin
        logic [DW-1:0] pats[4];
        logic [DW-1:0] words[5];
        logic [DW-1:0] w;
        int unsigned   st, n, k;
        logic          hit;

        rstn  = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset", {cnv, sclk, valid, busy, export_state, data}, 0);
        rstn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_hold", {cnv, sclk, valid, busy, export_state, data}, 0);
        end

        run_one(16'h004F, "single");

        pats[0] = 16'h0000;
        pats[1] = 16'hFFFF;
        pats[2] = 16'hA5A5;
        pats[3] = 16'h8001;
        for (int i = 0; i < 4; i++) run_one(pats[i], "pattern");
        for (int i = 0; i < 3; i++) run_one(DW'($urandom), "random");

        // start held high: back-to-back conversions
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            words[i] = DW'($urandom);
            adc_q.push_back(words[i]);
        end
        @(negedge clk);
        start = 1'b1;
        st    = cyc + 1;
        n = 0;
        k = 0;
        while (n < 5 && k < 5 * (N + 1) + 100) begin
            @(negedge clk);
            k++;
            if (valid) begin
                n++;
                if (n == 5) start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (N + 50) @(negedge clk);
        check("held_count", got_data.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_data.size()) begin
                check("held_data", got_data[i], words[i]);
                check("held_cyc", got_cyc[i] - st, N + i * (N + 1));
            end
        end

        // start pulses while busy are ignored
        clear_mon();
        adc_q.delete();
        w = 16'hC3C3;
        adc_q.push_back(w);
        @(negedge clk);
        start = 1'b1;
        st    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_conv_state", export_state, 1);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (export_state == 3'd2) hit = 1'b1;
        end
        check("ign_reach_acq", hit, 1);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valids(1, N + 50, "ignore");
        repeat (N + 50) @(negedge clk);
        check("ign_count", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check("ign_data", got_data[0], w);
            check("ign_latency", got_cyc[0] - st, N);
        end

        // reset in the middle of ACQ with sclk high
        clear_mon();
        adc_q.push_back(DW'($urandom));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (export_state == 3'd2 && sclk && rises > 4) hit = 1'b1;
        end
        check("rst_reach_acq", hit, 1);
        rstn = 1'b0;
        #1;
        check("rst_async", {cnv, sclk, valid, busy, export_state, data}, 0);
        @(negedge clk);
        rstn = 1'b1;
        adc_q.delete();
        repeat (5) @(negedge clk);
        check("rst_no_valid", got_data.size(), 0);
        run_one(16'h1234, "after_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
